// File: rtl/rvm_mem_responder.sv
// Word-organised single-port memory responder for the rvm mem_* bus.
// Inserts WAIT_CYCLES stall cycles, commits byte-enabled writes, returns registered read data.
module rvm_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_c_en,
    input  logic        mem_w_en,
    input  logic [3:0]  mem_b_en,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_stall
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]   off;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic          commit;
    logic          wr_en;

    // 33-bit compare so that addresses below ADDR_BASE (wrapped) never alias into the array
    assign off      = mem_addr - ADDR_BASE;
    assign addr_err = (off[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    assign idx      = off[AW+1:2];

    always_comb begin
        commit = 1'b0;
        case (state_q)
            S_IDLE:  commit = mem_c_en && (WAIT_CYCLES == 0);
            S_WAIT:  commit = mem_c_en && (wcnt_q == 4'd0);
            default: commit = 1'b0;
        endcase
    end

    assign wr_en = resetn && commit && mem_w_en && !addr_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (commit) begin
                err_q <= addr_err;
                if (addr_err)
                    rdata_q <= 32'd0;
                else if (!mem_w_en)
                    rdata_q <= mem_q[idx];
            end
            case (state_q)
                S_IDLE: begin
                    if (mem_c_en) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            wcnt_q  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_c_en)
                        state_q <= S_IDLE;
                    else if (wcnt_q == 4'd0)
                        state_q <= S_RESP;
                    else
                        wcnt_q <= wcnt_q - 4'd1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_b_en[i])
                    mem_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_error = err_q && (state_q == S_RESP);
    assign mem_stall = resetn && mem_c_en && (state_q != S_RESP);

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Directed bench for rvm_mem_responder: three instances with WAIT_CYCLES 1, 3 and 0.
module tb_rvm_mem_responder;
    logic        clk = 1'b0;
    logic        rstn  [3];
    logic [31:0] addr  [3];
    logic        cen   [3];
    logic        wen   [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        stall [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvm_mem_responder #(.DEPTH(64), .WAIT_CYCLES(1), .ADDR_BASE(32'h0)) u_w1 (
        .clk(clk), .resetn(rstn[0]), .mem_addr(addr[0]), .mem_c_en(cen[0]), .mem_w_en(wen[0]),
        .mem_b_en(be[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_error(err[0]), .mem_stall(stall[0]));
    rvm_mem_responder #(.DEPTH(64), .WAIT_CYCLES(3), .ADDR_BASE(32'h0)) u_w3 (
        .clk(clk), .resetn(rstn[1]), .mem_addr(addr[1]), .mem_c_en(cen[1]), .mem_w_en(wen[1]),
        .mem_b_en(be[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_error(err[1]), .mem_stall(stall[1]));
    rvm_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) u_w0 (
        .clk(clk), .resetn(rstn[2]), .mem_addr(addr[2]), .mem_c_en(cen[2]), .mem_w_en(wen[2]),
        .mem_b_en(be[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_error(err[2]), .mem_stall(stall[2]));

    function automatic int wc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    // Runs one request starting just after a rising edge; returns per-cycle stall, RESP data/error
    // and the error output in the cycle after RESP. Leaves the bus idle just after a rising edge.
    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output logic [7:0] st, output logic er_after);
        int wc;
        wc = wc_of(d);
        st = 8'd0;
        cen[d] = 1'b1; wen[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        for (int k = 0; k <= wc; k++) begin
            @(negedge clk); st[k] = stall[d];
            @(posedge clk); #1;
        end
        @(negedge clk);
        st[wc+1] = stall[d]; rd = rdata[d]; er = err[d];
        cen[d] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); er_after = err[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; cen[d] = 1'b1; wen[d] = 1'b0; addr[d] = 32'h0; be[d] = 4'h0; wdata[d] = 32'h0;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            checks++; if (stall[d] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %b exp 0", d, stall[d]); end
            checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_error[%0d] got %b exp 0", d, err[d]); end
            checks++; if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", d, rdata[d]); end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin cen[d] = 1'b0; rstn[d] = 1'b1; end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, st, ea);
        checks++; if (st !== 8'b011) begin errors++; $display("FAIL wr_stall got %b exp 011", st); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_error got %b exp 0", er); end
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (st !== 8'b011) begin errors++; $display("FAIL rd_stall got %b exp 011", st); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_error got %b exp 0", er); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        do_req(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, rd, er, st, ea);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL be_wr_holds_rdata got %h exp deadbeef", rd); end
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_merge got %h exp de22be44", rd); end
        do_req(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, st, ea);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_zero_error got %b exp 0", er); end
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero_data got %h exp de22be44", rd); end
    endtask

    task automatic test_addr_errors();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        do_req(0, 1'b1, 32'h0, 4'hF, 32'h0BADC0DE, rd, er, st, ea);
        do_req(0, 1'b0, 32'h100, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_error got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", rd); end
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL oor_rd_err_after got %b exp 0", ea); end
        do_req(0, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF, rd, er, st, ea);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_error got %b exp 1", er); end
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL oor_wr_err_after got %b exp 0", ea); end
        do_req(0, 1'b0, 32'h0, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL word0_intact got %h exp 0badc0de", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_error got %b exp 0", er); end
        do_req(0, 1'b0, 32'h12, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_error got %b exp 1", er); end
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL misaligned_err_after got %b exp 0", ea); end
        do_req(0, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL high_addr_error got %b exp 1", er); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        do_req(1, 1'b1, 32'h20, 4'hF, 32'h12345678, rd, er, st, ea);
        checks++; if (st !== 8'b01111) begin errors++; $display("FAIL w3_stall got %b exp 01111", st); end
        cen[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h20; be[1] = 4'hF; wdata[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cen[1] = 1'b0;
        #1;
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL abort_stall got %b exp 0", stall[1]); end
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (st !== 8'b01111) begin errors++; $display("FAIL abort_idle_latency got %b exp 01111", st); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_old_data got %h exp 12345678", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        st = 8'd0;
        cen[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h20; be[1] = 4'hF; wdata[1] = 32'hCAFEF00D;
        @(posedge clk); #1;
        #1; rstn[1] = 1'b0; #1;
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall[1]); end
        checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_error got %b exp 0", err[1]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata got %h exp 0", rdata[1]); end
        @(negedge clk); rstn[1] = 1'b1; #1;
        st[0] = stall[1];
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk); st[k] = stall[1];
        end
        rd = rdata[1]; er = err[1];
        cen[1] = 1'b0;
        @(posedge clk); #1;
        checks++; if (st !== 8'b01111) begin errors++; $display("FAIL rst_fresh_latency got %b exp 01111", st); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL rst_fresh_resp got %b/%h exp 0/0", er, rd); end
        do_req(1, 1'b0, 32'h20, 4'h0, 32'h0, rd, er, st, ea);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_fresh_data got %h exp cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er, ea; logic [7:0] st;
        logic [31:0] vals [4];
        vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0004; vals[2] = 32'h3333_0008; vals[3] = 32'h4444_000C;
        for (int i = 0; i < 4; i++) begin
            do_req(2, 1'b1, 32'(i*4), 4'hF, vals[i], rd, er, st, ea);
            checks++; if (st !== 8'b01) begin errors++; $display("FAIL w0_wr_stall[%0d] got %b exp 01", i, st); end
        end
        cen[2] = 1'b1; wen[2] = 1'b0; be[2] = 4'h0; addr[2] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (stall[2] !== 1'b1) begin errors++; $display("FAIL stream_req_stall[%0d] got %b exp 1", i, stall[2]); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (stall[2] !== 1'b0) begin errors++; $display("FAIL stream_resp_stall[%0d] got %b exp 0", i, stall[2]); end
            checks++; if (rdata[2] !== vals[i]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, rdata[2], vals[i]); end
            addr[2] = 32'((i+1)*4);
            if (i == 3) cen[2] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_addr_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
